// File: rtl/vga_pkg.sv
// Timing constants and state encoding shared by the VGA sync-recovery receiver.
// Defaults describe the 1024x768@60 stream from the pixel-clock timing generator.
package vga_pkg;
  localparam int H_ACTIVE   = 1024;
  localparam int H_FP       = 24;
  localparam int H_SYNC     = 136;
  localparam int H_BP       = 160;
  localparam int V_ACTIVE   = 768;
  localparam int V_FP       = 3;
  localparam int V_SYNC     = 6;
  localparam int V_BP       = 29;
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LOCK_LINES = 4;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int PER_W  = 11;
  localparam logic [PER_W-1:0] PER_MAX = '1;

  typedef logic [1:0] state_t;
  localparam state_t ST_SEARCH = 2'd0;
  localparam state_t ST_H_LOCK = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;
endpackage

// File: rtl/vga_timing_recover_if.sv
// Pin-level sync inputs and recovered timing outputs of the VGA receiver.
// master drives the sync pins; slave is the receiver.
interface vga_timing_recover_if;
  import vga_pkg::*;

  logic              hs_n_in;
  logic              vs_n_in;
  logic [HCNT_W-1:0] hcount_out;
  logic [VCNT_W-1:0] vcount_out;
  logic              blank_out;
  logic              locked_out;
  logic [PER_W-1:0]  line_len_out;
  logic              err_out;

  modport master (
    output hs_n_in, vs_n_in,
    input  hcount_out, vcount_out, blank_out, locked_out, line_len_out, err_out
  );
  modport slave (
    input  hs_n_in, vs_n_in,
    output hcount_out, vcount_out, blank_out, locked_out, line_len_out, err_out
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Falling-edge detector for an active-low sync pin; VGA_RX_SYNC_EN adds a
// two-flop synchronizer ahead of the edge register (latency 3 instead of 1).
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_n,
  output logic fall
);
  logic cur, prev;

`ifdef VGA_RX_SYNC_EN
  logic [1:0] meta;
  always_ff @(posedge clk) begin
    if (!rst_n) meta <= 2'b11;
    else        meta <= {meta[0], sync_n};
  end
  assign cur = meta[1];
`else
  assign cur = sync_n;
`endif

  // Preset high so an idle (high) pin never looks like an edge after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= cur;
  end

  assign fall = prev & ~cur;
endmodule

// File: rtl/vga_timing_recover.sv
// Rebuilds generator hcount/vcount/blank from pin-level hsync/vsync and
// tracks lock through hsync-period and frame-length checks.
module vga_timing_recover
  import vga_pkg::*;
#(
  parameter int H_ACT    = H_ACTIVE,
  parameter int H_FRONT  = H_FP,
  parameter int H_SYNC_W = H_SYNC,
  parameter int H_BACK   = H_BP,
  parameter int V_ACT    = V_ACTIVE,
  parameter int V_FRONT  = V_FP,
  parameter int V_SYNC_W = V_SYNC,
  parameter int V_BACK   = V_BP,
  parameter int LOCK_N   = LOCK_LINES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_timing_recover_if.slave  bus
);
  localparam int HT = H_ACT + H_FRONT + H_SYNC_W + H_BACK;
  localparam int VT = V_ACT + V_FRONT + V_SYNC_W + V_BACK;
  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(HT - 1);
  localparam logic [HCNT_W-1:0] H_SYNC_POS = HCNT_W'(H_ACT + H_FRONT);
  localparam logic [HCNT_W-1:0] H_VIS      = HCNT_W'(H_ACT);
  localparam logic [VCNT_W-1:0] V_LAST     = VCNT_W'(VT - 1);
  localparam logic [VCNT_W-1:0] V_SYNC_POS = VCNT_W'(V_ACT + V_FRONT);
  localparam logic [VCNT_W-1:0] V_VIS      = VCNT_W'(V_ACT);
  localparam logic [VCNT_W-1:0] V_PER      = VCNT_W'(VT);
  localparam logic [PER_W-1:0]  H_PER      = PER_W'(HT);
  localparam logic [PER_W-1:0]  PER_PRE    = PER_MAX - 1'b1;

  logic              hs_fall, vs_fall, h_wrap, h_bad, v_bad, v_armed, err;
  logic [HCNT_W-1:0] hcount;
  logic [VCNT_W-1:0] vcount, lines, v_len;
  logic [PER_W-1:0]  period, line_len;
  logic [GW-1:0]     good;
  state_t            state;

  sync_edge_detect u_hs (.clk(clk), .rst_n(rst_n), .sync_n(bus.hs_n_in), .fall(hs_fall));
  sync_edge_detect u_vs (.clk(clk), .rst_n(rst_n), .sync_n(bus.vs_n_in), .fall(vs_fall));

  assign h_wrap = ~hs_fall & (hcount == H_LAST);
  // A wrap coinciding with vsync closes the frame being measured.
  assign v_len  = lines + VCNT_W'(h_wrap);
  // Missing hsync is reported once, on the cycle the period counter saturates.
  assign h_bad  = hs_fall ? (period != H_PER) : (period == PER_PRE);
  assign v_bad  = vs_fall ? (v_len != V_PER) : (h_wrap & (lines == V_LAST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount   <= '0;
      vcount   <= '0;
      lines    <= '0;
      period   <= '0;
      line_len <= '0;
    end else begin
      if (hs_fall)     hcount <= H_SYNC_POS;
      else if (h_wrap) hcount <= '0;
      else             hcount <= hcount + 1'b1;

      if (vs_fall)     vcount <= V_SYNC_POS;
      else if (h_wrap) vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;

      if (vs_fall)     lines <= '0;
      else if (h_wrap) lines <= lines + 1'b1;

      if (hs_fall) begin
        line_len <= period;
        period   <= PER_W'(1);
      end else if (period != PER_MAX) begin
        period   <= period + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_SEARCH;
      good    <= '0;
      v_armed <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_SEARCH: begin
          v_armed <= 1'b0;
          if (hs_fall) begin
            if (period != H_PER)              good <= '0;
            else if (good == GW'(LOCK_N - 1)) begin
              good  <= '0;
              state <= ST_H_LOCK;
            end else                          good <= good + 1'b1;
          end
        end
        ST_H_LOCK: begin
          if (h_bad) begin
            err     <= 1'b1;
            v_armed <= 1'b0;
            state   <= ST_SEARCH;
          end else if (vs_fall) begin
            // A wrong frame length here just restarts the measurement.
            if (v_armed && v_len == V_PER) state <= ST_LOCKED;
            v_armed <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (h_bad | v_bad) begin
            err     <= 1'b1;
            v_armed <= 1'b0;
            state   <= ST_SEARCH;
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

  assign bus.hcount_out   = hcount;
  assign bus.vcount_out   = vcount;
  assign bus.locked_out   = (state == ST_LOCKED);
  assign bus.blank_out    = (state != ST_LOCKED) | (hcount >= H_VIS) | (vcount >= V_VIS);
  assign bus.line_len_out = line_len;
  assign bus.err_out      = err;
endmodule

// File: doc/vga_timing_recover.md
# vga_timing_recover

Sync-recovery receiver for the 1024x768@60 VGA stream produced by our pixel-clock timing generator. Samples the active-low pin-level hsync/vsync and rebuilds hcount/vcount/blank, exactly as the generator's counters, delayed by a fixed latency. Tracks lock with a line/frame-length checker. Used for loopback self-test of the display path and as the front end of future capture blocks, clocked from the same 65 MHz pixel clock.

## Interface
- H_ACTIVE, 1024, active pixels per line
- H_FP, 24, horizontal front porch
- H_SYNC, 136, hsync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, active lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vsync width
- V_BP, 29, vertical back porch
- LOCK_LINES, 4, consecutive good lines required for horizontal lock
- clk  in  1  pixel clock (65 MHz); all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- hs_n_in  in  1  pin-level hsync, active low
- vs_n_in  in  1  pin-level vsync, active low
- hcount_out  out  11  recovered pixel index, 0..H_TOTAL-1
- vcount_out  out  10  recovered line index, 0..V_TOTAL-1
- blank_out  out  1  high outside active area or when not locked
- locked_out  out  1  full frame lock
- line_len_out  out  11  last measured hsync-to-hsync period
- err_out  out  1  one-cycle pulse on any period mismatch while H_LOCK/LOCKED

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL likewise (806). Generator places hsync assertion at hcount = H_ACTIVE+H_FP (1048), vsync assertion at line V_ACTIVE+V_FP (771), hcount 0.
- Edge detect: sync start = sampled level 1 -> 0 on the (optionally synchronized) input.
- h counter: free-running 0..H_TOTAL-1 wrap; on hsync start, loaded so hcount_out aligns with the generator (value 1048 at the aligned cycle).
- v counter: increments on h wrap, wraps at V_TOTAL-1 -> 0; on vsync start, forced to 771.
- Period counter: counts clk between hsync starts, saturates at 2047; latched into line_len_out on each hsync start, then restarts at 1.
- FSM states SEARCH, H_LOCK, LOCKED:
  - SEARCH: on hsync start with period == H_TOTAL, increment good-line count; at LOCK_LINES -> H_LOCK. Mismatch clears count.
  - H_LOCK: on vsync start, begin line count; at next vsync start, lines == V_TOTAL -> LOCKED, else stay H_LOCK and restart.
  - LOCKED: stays while every hsync period == H_TOTAL and every vsync period == V_TOTAL lines.
  - Any mismatch in H_LOCK/LOCKED: err_out pulses 1 cycle, -> SEARCH, counts cleared.
  - Missing hsync (period saturates at 2047) treated as mismatch at saturation.
- blank_out = ~locked_out | hcount_out >= H_ACTIVE | vcount_out >= V_ACTIVE.
- Simultaneous hsync and vsync start: both processed same cycle; vsync load of v counter takes priority over increment on h wrap.

## Timing
- Reset (rst_n low at a clk edge): hcount_out 0, vcount_out 0, blank_out 1, locked_out 0, line_len_out 0, err_out 0, state SEARCH, edge detectors preset to 1 (no false edge out of reset).
- Latency L from pin to outputs: 1 cycle without synchronizer, 3 with. In LOCKED, hcount_out/vcount_out at cycle t equal the generator's counts at t-L.
- locked_out rises on the cycle after the qualifying vsync start is registered; earliest ≈ LOCK_LINES lines + 2 frames after reset.
- err_out registered; asserted for exactly one cycle per mismatch.
- Reset mid-frame: immediate return to reset values; reacquisition from scratch.

## Configuration
- VGA_RX_SYNC_EN defined: two-flop synchronizer on hs_n_in and vs_n_in, L = 3; required when the source is external/asynchronous.
- Undefined: inputs sampled by a single register, L = 1; valid only for same-clock loopback.

## Structure
- Shared package vga_pkg: timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL, widths), state enum typedef, LOCK_LINES default.
- One sub-module: sync_edge_detect (optional synchronizer + falling-edge pulse), instantiated twice.

## Test plan
- Loopback from timing generator after reset -> locked_out high after 4 lines + 2 frames; thereafter hcount_out/vcount_out equal generator counts delayed by L every cycle; line_len_out = 1344.
- Single line with hsync period 1343 while LOCKED -> err_out one pulse, locked_out 0 next cycle, blank_out 1; relock after 4 good lines + 2 frames.
- Hsync held high (disconnected) while LOCKED -> err_out pulse when period reaches 2047, state SEARCH.
- Frame with 805 lines in H_LOCK -> no LOCKED transition, no err; next 806-line frame -> locked_out 1.
- rst_n low for 1 cycle at line 400, pixel 500 -> all outputs at reset values next cycle; no err_out pulse.
- VGA_RX_SYNC_EN both defined and undefined -> alignment check passes with L = 3 and L = 1 respectively.
